letreiro_scroll_decoder: RTL and testbench

- Scrolling-marquee core for the three leftmost 7-segment digits of the sign.
- Holds the 3-bit scroll position counter, clocked by the slow divided clock novo_clock1.
- Decodes that position into three active-low segment patterns.
- Each digit shows one character of a fixed 8-character circular message, offset by its digit index, so the text scrolls one digit per slow-clock tick.

---
 rtl/letreiro_scroll_decoder.sv | 55 +++++
 tb/tb_letreiro_scroll_decoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/letreiro_scroll_decoder.sv
// Scrolling marquee for the three leftmost 7-segment digits: a 3-bit position counter
// and three active-low decoders showing consecutive characters of an 8-entry circular message.
module letreiro_scroll_decoder (
  input  logic       novo_clock1,
  input  logic       reset,
  output logic [2:0] pos,
  output logic [0:6] hex_a,
  output logic [0:6] hex_b,
  output logic [0:6] hex_c
);

  logic [2:0] r_q;
  logic [2:0] w_q_next;
  logic [2:0] w_idx_b;
  logic [2:0] w_idx_c;

  // Index 0 of each pattern is segment a; all patterns are active-low.
  function automatic logic [0:6] msg_char(input logic [2:0] idx);
    logic [0:6] seg;
    seg = 7'b1111111;
    unique case (idx)
      3'd0: seg = 7'b1001000; // H
      3'd1: seg = 7'b0110000; // E
      3'd2: seg = 7'b1110001; // L
      3'd3: seg = 7'b1110001; // L
      3'd4: seg = 7'b0000001; // O
      3'd5: seg = 7'b1111111;
      3'd6: seg = 7'b1111110; // -
      3'd7: seg = 7'b1111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Natural 3-bit wrap gives the circular message for free.
  assign w_q_next = r_q + 3'd1;
  assign w_idx_b  = r_q + 3'd1;
  assign w_idx_c  = r_q + 3'd2;

  always_ff @(posedge novo_clock1 or negedge reset) begin
    if (!reset) begin
      r_q <= 3'd0;
    end else begin
      r_q <= w_q_next;
    end
  end

  always_comb begin
    pos   = r_q;
    hex_a = msg_char(r_q);
    hex_b = msg_char(w_idx_b);
    hex_c = msg_char(w_idx_c);
  end

endmodule

// File: tb/tb_letreiro_scroll_decoder.sv
// Directed bench for letreiro_scroll_decoder: per-position vector table plus
// async-reset and digit-offset sequences.
module tb_letreiro_scroll_decoder;

  logic       novo_clock1;
  logic       reset;
  logic [2:0] pos;
  logic [0:6] hex_a;
  logic [0:6] hex_b;
  logic [0:6] hex_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] q;
    logic [0:6] a;
    logic [0:6] b;
    logic [0:6] c;
  } vec_t;

  vec_t tbl [8];

  letreiro_scroll_decoder dut (
    .novo_clock1 (novo_clock1),
    .reset       (reset),
    .pos         (pos),
    .hex_a       (hex_a),
    .hex_b       (hex_b),
    .hex_c       (hex_c)
  );

  task automatic tick();
    #5 novo_clock1 = 1'b1;
    #5 novo_clock1 = 1'b0;
  endtask

  task automatic check_vec(input string name, input vec_t v);
    checks++;
    if (pos !== v.q || hex_a !== v.a || hex_b !== v.b || hex_c !== v.c) begin
      errors++;
      $display("FAIL %s: got pos=%b a=%b b=%b c=%b, want pos=%b a=%b b=%b c=%b",
               name, pos, hex_a, hex_b, hex_c, v.q, v.a, v.b, v.c);
    end
  endtask

  task automatic check_seg(input string name, input logic [0:6] got, input logic [0:6] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  initial begin
    logic [0:6] prev_b;
    logic [0:6] prev_c;
    logic [0:6] prev2_c;
    logic [2:0] model_q;

    tbl[0] = '{3'd0, 7'b1001000, 7'b0110000, 7'b1110001};
    tbl[1] = '{3'd1, 7'b0110000, 7'b1110001, 7'b1110001};
    tbl[2] = '{3'd2, 7'b1110001, 7'b1110001, 7'b0000001};
    tbl[3] = '{3'd3, 7'b1110001, 7'b0000001, 7'b1111111};
    tbl[4] = '{3'd4, 7'b0000001, 7'b1111111, 7'b1111110};
    tbl[5] = '{3'd5, 7'b1111111, 7'b1111110, 7'b1111111};
    tbl[6] = '{3'd6, 7'b1111110, 7'b1111111, 7'b1001000};
    tbl[7] = '{3'd7, 7'b1111111, 7'b1001000, 7'b0110000};

    novo_clock1 = 1'b0;
    reset       = 1'b0;
    #3;
    check_vec("reset_no_clock", tbl[0]);
    tick();
    check_vec("reset_held_over_edge", tbl[0]);

    reset = 1'b1;
    #2;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_vec($sformatf("edge_%0d", i), tbl[i % 8]);
    end

    // Advance to position 3, then pulse reset between edges.
    for (int i = 0; i < 3; i++) tick();
    check_vec("pos3_before_pulse", tbl[3]);
    #2 reset = 1'b0;
    #1;
    check_vec("async_reset_immediate", tbl[0]);
    #1 reset = 1'b1;
    #1;
    check_vec("after_release_no_edge", tbl[0]);
    tick();
    check_vec("first_edge_after_release", tbl[1]);

    // Digit offsets over 16 edges: hex_b leads hex_a by one, hex_c by two.
    model_q = 3'd1;
    prev_b  = hex_b;
    prev_c  = hex_c;
    prev2_c = 7'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      model_q = model_q + 3'd1;
      check_vec($sformatf("run_%0d", k), tbl[model_q]);
      check_seg($sformatf("b_leads_a_%0d", k), hex_a, prev_b);
      if (k >= 2) check_seg($sformatf("c_leads_a_%0d", k), hex_a, prev2_c);
      prev2_c = prev_c;
      prev_b  = hex_b;
      prev_c  = hex_c;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
